// File: rtl/grant_burst_ctrl_pkg.sv
// Shared types and defaults for the grant burst controller.
package grant_burst_ctrl_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grant_burst_ctrl_onehot_to_idx.sv
// Converts a grant vector to its set-bit index plus one-hot / multi-hot flags.
// Purely combinational; no backpressure.
module onehot_to_idx
  import grant_burst_ctrl_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld,
  output logic             multi
);

  logic             any_set;
  logic             more_than_one;
  logic [N-1:0]     low_cleared;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign low_cleared   = vec & (vec - N'(1));
  assign any_set       = |vec;
  assign more_than_one = |low_cleared;
  assign vld           = any_set && !more_than_one;
  assign multi         = more_than_one;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/grant_burst_ctrl.sv
// Turns a one-hot grant into a burst of beats and pulses done to the owner.
// Latency: grant to first beat 1 cycle, last accepted beat to done 1 cycle.
// Backpressure: beat_valid holds with owner/beat_idx stable until beat_ready.
module grant_burst_ctrl
  import grant_burst_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  localparam int OWN_W  = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ*LEN_W-1:0] burst_len,
  input  logic                     beat_ready,
  output logic                     beat_valid,
  output logic [OWN_W-1:0]         owner,
  output logic [LEN_W-1:0]         beat_idx,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done,
  output logic                     gnt_err
);

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [LEN_W-1:0]     beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 beat_valid_q, beat_valid_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 gnt_err_q, gnt_err_d;

  logic [OWN_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 gnt_multi;
  logic [LEN_W-1:0]     sel_len;

  onehot_to_idx #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_onehot_to_idx (
    .vec   (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld),
    .multi (gnt_multi)
  );

  assign sel_len = burst_len[gnt_idx*LEN_W +: LEN_W];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_idx_d   = beat_idx_q;
    remaining_d  = remaining_q;
    beat_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = '0;
    gnt_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d      = gnt_idx;
          beat_idx_d   = '0;
          // A zero-length request still moves one beat.
          remaining_d  = (sel_len == '0) ? LEN_W'(1) : sel_len;
          state_d      = ST_XFER;
          beat_valid_d = 1'b1;
          busy_d       = 1'b1;
        end else if (gnt_multi) begin
          gnt_err_d    = 1'b1;
        end
      end

      ST_XFER: begin
        beat_valid_d = 1'b1;
        busy_d       = 1'b1;
        if (beat_valid_q && beat_ready) begin
          if (remaining_q == LEN_W'(1)) begin
            // Last beat: beat_idx is held so a full-length burst never wraps.
            state_d      = ST_DONE;
            beat_valid_d = 1'b0;
            done_d       = NUM_REQ'(1) << owner_q;
          end else begin
            beat_idx_d  = beat_idx_q + LEN_W'(1);
            remaining_d = remaining_q - LEN_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        beat_idx_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      beat_idx_q   <= '0;
      remaining_q  <= '0;
      beat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      gnt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_idx_q   <= beat_idx_d;
      remaining_q  <= remaining_d;
      beat_valid_q <= beat_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      gnt_err_q    <= gnt_err_d;
    end
  end

  assign beat_valid = beat_valid_q;
  assign owner      = owner_q;
  assign beat_idx   = beat_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gnt_err    = gnt_err_q;

endmodule
